bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_pkg.sv | 16 +
 rtl/bus_arbiter_rr_pick.sv | 29 ++
 rtl/bus_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding and constants used by
// masters, slaves and the central arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_LEN = 6;
  localparam int unsigned MAX_MASTERS         = 8;
  localparam logic        SLV_BSY_ASSERT      = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the pointer,
// scanning ptr+1, ptr+2, ... modulo N.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid_c,
  output logic [IW-1:0] o_idx_c
);

  int unsigned w_pos;

  // Scan farthest-first so the nearest requester after the pointer wins.
  always_comb begin
    o_valid_c = 1'b0;
    o_idx_c   = '0;
    w_pos     = 0;
    for (int unsigned k = N; k > 0; k--) begin
      w_pos = (32'(i_ptr) + k) % N;
      if (i_req[w_pos]) begin
        o_valid_c = 1'b1;
        o_idx_c   = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central bus arbiter: round-robin one-hot grant, ownership tracking via the
// wired utilizing line, grant-to-use timeout and slave-busy drive in GRANT.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned TIMEOUT_LEN = DEFAULT_TIMEOUT_LEN,
  localparam int unsigned IW         = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] b_request,
  input  logic                   b_bus_utilizing,
  output logic [NUM_MASTERS-1:0] b_grant,
  output logic [IW-1:0]          grant_id,
  output logic                   arbiter_drive,
  output logic                   arb_out,
  output logic                   timeout_pulse
);

  arb_state_e             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]          r_grant_id, w_id_nxt;
  logic [TIMEOUT_LEN-1:0] r_timer, w_timer_nxt;
  logic                   r_timer_sat, w_sat_nxt;
  logic                   r_drive, w_drive_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic                   r_arb_out;
  logic                   w_pick_valid;
  logic [IW-1:0]          w_pick_idx;

  rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_rr_pick (
    .i_req     (b_request),
    .i_ptr     (r_grant_id),
    .o_valid_c (w_pick_valid),
    .o_idx_c   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_grant_id  <= IW'(NUM_MASTERS - 1);
      r_timer     <= '0;
      r_timer_sat <= 1'b0;
      r_drive     <= 1'b0;
      r_timeout   <= 1'b0;
      r_arb_out   <= SLV_BSY_ASSERT;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_id  <= w_id_nxt;
      r_timer     <= w_timer_nxt;
      r_timer_sat <= w_sat_nxt;
      r_drive     <= w_drive_nxt;
      r_timeout   <= w_timeout_nxt;
      r_arb_out   <= SLV_BSY_ASSERT;
    end
  end

  // Timer counts up to all ones, then one more saturated cycle before expiry,
  // so an unused grant stays up 2^TIMEOUT_LEN+1 cycles.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_id_nxt      = r_grant_id;
    w_timer_nxt   = r_timer;
    w_sat_nxt     = r_timer_sat;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (w_pick_valid && !b_bus_utilizing) begin
          w_grant_nxt = NUM_MASTERS'(1) << w_pick_idx;
          w_id_nxt    = w_pick_idx;
          w_timer_nxt = '0;
          w_sat_nxt   = 1'b0;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (b_bus_utilizing) begin
          w_state_nxt = ST_BUSY;
        end else if (!b_request[r_grant_id]) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = '0;
        end else if (r_timer_sat) begin
          w_state_nxt   = ST_RELEASE;
          w_grant_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end else if (r_timer == '1) begin
          w_sat_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TIMEOUT_LEN'(1);
        end
      end
      ST_BUSY: begin
        if (!b_bus_utilizing) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = '0;
        end
      end
      ST_RELEASE: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_drive_nxt = (w_state_nxt == ST_GRANT);
  end

  assign b_grant       = r_grant;
  assign grant_id      = r_grant_id;
  assign arbiter_drive = r_drive;
  assign arb_out       = r_arb_out;
  assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_bus_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned TL = 6;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] b_request;
  logic       b_bus_utilizing;
  logic [2:0] b_grant;
  logic [1:0] grant_id;
  logic       arbiter_drive;
  logic       arb_out;
  logic       timeout_pulse;

  int tests = 0;
  int fails = 0;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_LEN(TL)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .b_request       (b_request),
    .b_bus_utilizing (b_bus_utilizing),
    .b_grant         (b_grant),
    .grant_id        (grant_id),
    .arbiter_drive   (arbiter_drive),
    .arb_out         (arb_out),
    .timeout_pulse   (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Invariants: at most one grant; the slave-busy driver only with a live grant.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      tests++;
      if (!$onehot0(b_grant) || (arbiter_drive && b_grant == 3'b000)) begin
        fails++;
        $display("FAIL invariant: grant=%b drive=%b", b_grant, arbiter_drive);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Ownership model: who holds the grant, whether it has been used, how long
  // it has waited unused, and whether a release cycle is pending.
  int m_owner, m_ptr, m_age;
  bit m_used, m_rel, m_to;

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_age = 0;
    m_used = 0; m_rel = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [2:0] req, input logic util);
    m_to = 0;
    if (m_rel) begin
      m_rel = 0;
    end else if (m_owner < 0) begin
      if (req != 3'b000 && !util) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (req[c]) begin
            m_owner = c;
            break;
          end
        end
        m_ptr = m_owner; m_age = 0; m_used = 0;
      end
    end else if (!m_used) begin
      if (util) m_used = 1;
      else if (!req[m_owner]) begin m_owner = -1; m_rel = 1; end
      else if (m_age == (1 << TL)) begin m_owner = -1; m_rel = 1; m_to = 1; end
      else m_age++;
    end else if (!util) begin
      m_owner = -1; m_rel = 1;
    end
  endtask

  function automatic logic [7:0] model_outs();
    logic [2:0] g;
    g = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    return {g, 2'(m_ptr), (m_owner >= 0 && !m_used), m_to, 1'b1};
  endfunction

  task automatic do_reset(input logic [2:0] req);
    @(negedge clk);
    rstn = 1'b0; b_request = req; b_bus_utilizing = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [2:0] req;
    logic       util;
    logic [2:0] grant;
    logic [1:0] id;
    logic       drive;
    logic       to;
  } vec_t;

  vec_t vecs[15];
  int   rr_exp[4];

  initial begin
    int low, hi, pulses;
    bit got, first_low_pulse;

    vecs[0]  = '{3'b010, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0};
    vecs[1]  = '{3'b010, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0};
    vecs[4]  = '{3'b000, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0};
    vecs[7]  = '{3'b000, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{3'b000, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0};
    vecs[10] = '{3'b000, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0};
    vecs[11] = '{3'b111, 1'b1, 3'b000, 2'd2, 1'b0, 1'b0};
    vecs[12] = '{3'b111, 1'b1, 3'b000, 2'd2, 1'b0, 1'b0};
    vecs[13] = '{3'b111, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{3'b111, 1'b1, 3'b001, 2'd0, 1'b0, 1'b0};
    rr_exp = '{0, 1, 2, 0};

    rstn = 1'b0; b_request = 3'b000; b_bus_utilizing = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {b_grant, grant_id, arbiter_drive, timeout_pulse, arb_out},
          {3'b000, 2'd2, 1'b0, 1'b0, 1'b1});
    rstn = 1'b1;

    // Single request, busy hold, withdrawal, foreign owner.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      b_request = vecs[i].req; b_bus_utilizing = vecs[i].util;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {b_grant, grant_id, arbiter_drive, timeout_pulse},
            {vecs[i].grant, vecs[i].id, vecs[i].drive, vecs[i].to});
    end

    // Asynchronous reset while master 0 owns the bus.
    #2 rstn = 1'b0;
    #1 check("async_reset", {b_grant, grant_id, arbiter_drive, timeout_pulse, arb_out},
             {3'b000, 2'd2, 1'b0, 1'b0, 1'b1});
    @(negedge clk); rstn = 1'b1;

    // Round robin with every master requesting and using the bus 4 cycles.
    do_reset(3'b111);
    for (int r = 0; r < 4; r++) begin
      low = 0; got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (b_grant != 3'b000) got = 1; else low++;
      end
      check($sformatf("rr_seen%0d", r), 32'(got), 32'd1);
      check($sformatf("rr_order%0d", r), 32'(grant_id), 32'(rr_exp[r]));
      check($sformatf("rr_grant%0d", r), 32'(b_grant), 32'(1 << rr_exp[r]));
      if (r > 0) check($sformatf("rr_gap%0d", r), 32'(low >= 2), 32'd1);
      b_bus_utilizing = 1'b1;
      repeat (4) @(negedge clk);
      b_bus_utilizing = 1'b0;
    end

    // Unused grant to master 0 times out, then master 1 is served.
    do_reset(3'b011);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (b_grant == 3'b001) got = 1;
    end
    check("to_first_grant", 32'(got), 32'd1);
    hi = 1; pulses = 0; first_low_pulse = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (timeout_pulse) pulses++;
      if (b_grant != 3'b001) begin
        first_low_pulse = timeout_pulse;
        break;
      end
      hi++;
    end
    check("to_grant_cycles", 32'(hi), 32'((1 << TL) + 1));
    check("to_pulse_at_drop", 32'(first_low_pulse), 32'd1);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (timeout_pulse) pulses++;
      if (b_grant != 3'b000) got = 1;
    end
    check("to_pulse_count", 32'(pulses), 32'd1);
    check("to_next_id", {31'd0, got, 6'd0, grant_id}, {31'd0, 1'b1, 6'd0, 2'd1});

    // Randomized traffic against the ownership model.
    do_reset(3'b000);
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) b_request = 3'($urandom_range(7));
      if ($urandom_range(4) == 0) b_bus_utilizing = ~b_bus_utilizing;
      @(posedge clk);
      model_step(b_request, b_bus_utilizing);
      #1;
      check($sformatf("rand%0d", i),
            {24'd0, b_grant, grant_id, arbiter_drive, timeout_pulse, arb_out},
            {24'd0, model_outs()});
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
